// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a uart transmitter; one byte per transmit handshake, re-pulsed if unacknowledged.
// Latency: a write into an empty, idle queue produces tx_transmit in the cycle after the second following edge.
// Backpressure: writes while full are dropped and flagged in sticky overflow; draining waits on tx_busy.
module uart_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              iCE_CLK,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_overflow,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              tx_transmit,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  output logic              idle
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  state_t            state_q, state_d;
  logic              tx_transmit_q, tx_transmit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_ok;
  logic              pop;

  // FIFO bookkeeping: full is the pre-edge flag, so a write on a pop edge while full is still dropped
  always_comb begin
    wr_ok      = wr_en && !full_q;
    pop        = (state_q == S_LOAD);
    wr_ptr_d   = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    if (wr_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!wr_ok && pop) begin
      level_d = level_q - 1'b1;
    end
    full_d     = (level_d == (ADDR_W + 1)'(DEPTH));
    empty_d    = (level_d == '0);
    // A dropped write on the same edge as a clear keeps the flag set
    overflow_d = overflow_q;
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Transmit sequencer next-state; tx_transmit is registered and high exactly while in START
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !tx_busy) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_byte_d = mem_q[rd_ptr_q];
        state_d   = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // No acknowledge in time: re-pulse the byte already held in tx_byte
          if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
            state_d = S_START;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_transmit_d = (state_d == S_START);
  end

  // All control state, cleared immediately by reset
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      overflow_q    <= 1'b0;
      state_q       <= S_IDLE;
      tx_transmit_q <= 1'b0;
      tx_byte_q     <= 8'h00;
      cnt_q         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      tx_transmit_q <= tx_transmit_d;
      tx_byte_q     <= tx_byte_d;
      cnt_q         <= cnt_d;
    end
  end

  // Byte storage; contents need no reset since pointers and level gate every read
  always_ff @(posedge iCE_CLK) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign tx_transmit = tx_transmit_q;
  assign tx_byte     = tx_byte_q;
  assign idle        = empty_q && (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural uart model.
// Expected bytes are queued at write time and popped when the DUT pulses tx_transmit.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_queue;
  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_overflow = 1'b0;
  logic              hold_busy = 1'b0;
  logic              uart_busy = 1'b0;
  logic              tx_busy;
  logic              full, empty, overflow, tx_transmit, idle;
  logic [ADDR_W:0]   level;
  logic [7:0]        tx_byte;

  assign tx_busy = hold_busy | uart_busy;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .iCE_CLK     (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clr_overflow(clr_overflow),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .idle        (idle)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state (owned by the monitor process)
  logic [7:0] exp_q[$];
  int         m_level = 0;
  bit         m_ovf = 1'b0;
  int         cyc = 0;
  int         pulse_cnt = 0;
  int         last_wr_cyc = 0;
  int         last_pulse_cyc = 0;
  bit         retry_exp = 1'b0;
  bit         prev_tx = 1'b0;
  logic [7:0] last_byte = 8'h00;
  int         busy_cnt = 0;
  bit         raise_pend = 1'b0;
  int         ignore_done = 0;
  // Stimulus-owned knobs
  int         busy_len = 4;
  int         ignore_req = 0;

  always @(posedge clk) cyc++;

  // Monitor: uart model, scoreboard pop, per-cycle status checks, then write-side model for the coming edge
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) uart_busy = 1'b0;
    end
    if (raise_pend) begin
      raise_pend = 1'b0;
      uart_busy  = 1'b1;
      busy_cnt   = busy_len;
    end
    if (!rst_n) begin
      exp_q.delete();
      m_level   = 0;
      m_ovf     = 1'b0;
      retry_exp = 1'b0;
      prev_tx   = 1'b0;
    end else begin
      if (tx_transmit) begin
        pulse_cnt++;
        check("pulse_while_busy", int'(tx_busy), 0);
        check("back_to_back_pulse", int'(prev_tx), 0);
        if (retry_exp) begin
          check("retry_byte", int'(tx_byte), int'(last_byte));
          check("retry_spacing", cyc - last_pulse_cyc, ACK_TIMEOUT + 1);
          retry_exp  = 1'b0;
          raise_pend = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got byte 0x%0h, expected no pulse", tx_byte);
          end else begin
            last_byte = exp_q.pop_front();
            check("tx_byte_order", int'(tx_byte), int'(last_byte));
            m_level--;
          end
          if (ignore_done < ignore_req) begin
            ignore_done++;
            retry_exp = 1'b1;
          end else begin
            raise_pend = 1'b1;
          end
        end
        last_pulse_cyc = cyc;
      end
      prev_tx = tx_transmit;
      check("level", int'(level), m_level);
      check("full", int'(full), int'(m_level == DEPTH));
      check("empty", int'(empty), int'(m_level == 0));
      check("overflow", int'(overflow), int'(m_ovf));
      if (m_level != 0) check("idle_while_nonempty", int'(idle), 0);
      // Inputs now stable are consumed on the next rising edge, judged against the pre-edge count
      if (wr_en && m_level >= DEPTH) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (wr_en && m_level < DEPTH) begin
        exp_q.push_back(wr_data);
        m_level++;
        last_wr_cyc = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(idle && !tx_busy && exp_q.size() == 0 && !retry_exp) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got no drain in %0d cycles, expected idle queue", name, budget);
    end
    check({name, "_level"}, int'(level), 0);
    check({name, "_idle"}, int'(idle), 1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_level"}, int'(level), 0);
    check({name, "_empty"}, int'(empty), 1);
    check({name, "_full"}, int'(full), 0);
    check({name, "_overflow"}, int'(overflow), 0);
    check({name, "_tx_transmit"}, int'(tx_transmit), 0);
    check({name, "_tx_byte"}, int'(tx_byte), 0);
    check({name, "_idle"}, int'(idle), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    pc0;
    int    peak;
    int    n;
    int    guard;
    string s;

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Single byte with a long uart busy period
    busy_len = 100;
    pc0 = pulse_cnt;
    write_byte(8'h48);
    wait_drain("single", 400);
    check("single_pulse_count", pulse_cnt - pc0, 1);
    check("single_latency", last_pulse_cyc - last_wr_cyc, 2);
    check("single_tx_byte_held", int'(tx_byte), 8'h48);

    // Burst of "Hello World!" on consecutive cycles
    busy_len = 6;
    s = "Hello World!";
    peak = 0;
    for (int i = 0; i < 12; i++) begin
      wr_en   = 1'b1;
      wr_data = s[i];
      tick();
      if (int'(level) > peak) peak = int'(level);
    end
    wr_en = 1'b0;
    check("hello_peak_11_or_12", int'(peak == 11 || peak == 12), 1);
    wait_drain("hello", 1000);

    // Overflow while the uart is held busy externally
    hold_busy = 1'b1;
    busy_len  = 3;
    tick();
    for (int i = 0; i < 17; i++) write_byte(8'(i + 8'hA0));
    tick();
    check("ovf_full", int'(full), 1);
    check("ovf_level", int'(level), 16);
    check("ovf_flag", int'(overflow), 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    tick();
    check("ovf_cleared", int'(overflow), 0);

    // Release while full and keep writing: the writes on the decision and pop edges are dropped
    hold_busy = 1'b0;
    wr_en     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr_en = 1'b0;
    check("pop_edge_drop_ovf", int'(overflow), 1);
    check("pop_edge_drop_level", int'(level), 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;

    // Forty more bytes streamed with random pacing, random busy lengths and occasional ignored pulses
    n = 0;
    guard = 0;
    while (n < 40 && guard < 5000) begin
      busy_len = $urandom_range(1, 6);
      if ($urandom_range(0, 15) == 0) ignore_req++;
      if (!full && $urandom_range(0, 1) == 1) begin
        write_byte(8'($urandom_range(0, 255)));
        n++;
      end else begin
        tick();
      end
      guard++;
    end
    check("stream_count", n, 40);
    wait_drain("stream", 3000);
    ignore_req = ignore_done;

    // Acknowledge timeout: first pulse ignored, same byte re-pulsed once
    busy_len = 3;
    ignore_req++;
    pc0 = pulse_cnt;
    write_byte(8'hA5);
    wait_drain("ack_timeout", 200);
    check("ack_timeout_pulses", pulse_cnt - pc0, 2);

    // Asynchronous reset in the middle of a transmission with five bytes queued
    busy_len = 100;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h10 + i));
    n = 0;
    while (!uart_busy && n < 30) begin
      tick();
      n++;
    end
    check("rst_uart_busy_seen", int'(uart_busy), 1);
    tick();
    tick();
    check("rst_pre_level", int'(level), 5);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    pc0 = pulse_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (120) tick();
    check("post_reset_no_pulse", pulse_cnt - pc0, 0);
    check("post_reset_level", int'(level), 0);
    check("post_reset_idle", int'(idle), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
